// File: rtl/iter_divider.sv
// iter_divider
//   Multi-cycle radix-2 restoring divider for the EX stage. Accepts one request
//   through a valid/ready handshake, produces a 64-bit or word (Div32) quotient
//   or remainder with RISC-V divide-by-zero and overflow semantics, and holds
//   the result until the consumer takes it.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   div_valid_i       request valid        div_ready_o  idle, can accept
//   src1, src2        dividend, divisor    DivSel       operation code
//   Div32             word operation       flush_i      synchronous kill
//   out_valid_o       DivOut valid         out_ready_i  consumer takes result
//   DivOut            quotient/remainder   busy_o       CALC or DONE
module iter_divider #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            div_valid_i,
  output logic            div_ready_o,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  input  logic [2:0]      DivSel,
  input  logic            Div32,
  input  logic            flush_i,
  output logic            out_valid_o,
  input  logic            out_ready_i,
  output logic [XLEN-1:0] DivOut,
  output logic            busy_o
);

  // Operation codes shared with the ALU decode.
  localparam logic [2:0] DIV_DIV  = 3'd1;
  localparam logic [2:0] DIV_DIVU = 3'd2;
  localparam logic [2:0] DIV_REM  = 3'd3;
  localparam logic [2:0] DIV_REMU = 3'd4;

  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(XLEN) + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t          state_reg;
  logic [CW-1:0]   count_reg;
  logic [XLEN-1:0] divisor_reg;
  logic [XLEN-1:0] rem_reg;
  logic [XLEN-1:0] quo_reg;
  logic            neg_q_reg;
  logic            neg_r_reg;
  logic            w32_reg;
  logic            rem_sel_reg;
  logic [XLEN-1:0] div_out_reg;

  // ---------------- request decode and operand preparation ----------------
  logic            signed_op, rem_op, valid_op;
  logic [XLEN-1:0] op_a, op_b, word_src1;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] abs_a, abs_b;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] special_res;
  logic [XLEN-1:0] most_neg;

  always_comb begin
    signed_op = (DivSel == DIV_DIV) || (DivSel == DIV_REM);
    rem_op    = (DivSel == DIV_REM) || (DivSel == DIV_REMU);
    valid_op  = signed_op || (DivSel == DIV_DIVU) || (DivSel == DIV_REMU);

    // Word ops are worked at 64 bits with the operands extended; the
    // magnitudes still fit in the low half.
    op_a = src1;
    op_b = src2;
    if (Div32) begin
      op_a = signed_op ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : {{HALF{1'b0}}, src1[HALF-1:0]};
      op_b = signed_op ? {{HALF{src2[HALF-1]}}, src2[HALF-1:0]} : {{HALF{1'b0}}, src2[HALF-1:0]};
    end
    // Dividend as it appears in a result (word results are always sign-extended).
    word_src1 = Div32 ? {{HALF{src1[HALF-1]}}, src1[HALF-1:0]} : src1;

    a_neg = signed_op & op_a[XLEN-1];
    b_neg = signed_op & op_b[XLEN-1];
    abs_a = a_neg ? -op_a : op_a;
    abs_b = b_neg ? -op_b : op_b;

    most_neg = Div32 ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    div_zero = (op_b == '0);
    overflow = signed_op && (op_a == most_neg) && (op_b == '1);
    special  = !valid_op || div_zero || overflow;

    special_res = '0;
    if (!valid_op)
      special_res = '0;
    else if (div_zero)
      special_res = rem_op ? word_src1 : '1;
    else if (overflow)
      special_res = rem_op ? '0 : word_src1;
  end

  // ---------------- one restoring step and sign fixup ----------------
  logic [XLEN:0]   shifted, diff;
  logic            fits;
  logic [XLEN-1:0] step_rem, step_quo;
  logic [XLEN-1:0] q_raw, q_fix, r_fix, res_sel, final_res;

  always_comb begin
    shifted  = {rem_reg, quo_reg[XLEN-1]};
    diff     = shifted - {1'b0, divisor_reg};
    fits     = ~diff[XLEN];
    step_rem = fits ? diff[XLEN-1:0] : shifted[XLEN-1:0];
    step_quo = {quo_reg[XLEN-2:0], fits};

    // In word mode only the low half of the quotient register is meaningful.
    q_raw     = w32_reg ? {{HALF{1'b0}}, step_quo[HALF-1:0]} : step_quo;
    q_fix     = neg_q_reg ? -q_raw : q_raw;
    r_fix     = neg_r_reg ? -step_rem : step_rem;
    res_sel   = rem_sel_reg ? r_fix : q_fix;
    final_res = w32_reg ? {{HALF{res_sel[HALF-1]}}, res_sel[HALF-1:0]} : res_sel;
  end

  // ---------------- control and datapath state ----------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg   <= IDLE;
      count_reg   <= '0;
      divisor_reg <= '0;
      rem_reg     <= '0;
      quo_reg     <= '0;
      neg_q_reg   <= 1'b0;
      neg_r_reg   <= 1'b0;
      w32_reg     <= 1'b0;
      rem_sel_reg <= 1'b0;
      div_out_reg <= '0;
    end else if (flush_i) begin
      // Kill wins over accept and handoff; DivOut keeps its last value but is
      // never flagged valid.
      state_reg <= IDLE;
      count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (div_valid_i) begin
            if (special) begin
              div_out_reg <= special_res;
              state_reg   <= DONE;
            end else begin
              divisor_reg <= abs_b;
              rem_reg     <= '0;
              // Word dividend sits in the top half so it shifts out first.
              quo_reg     <= Div32 ? {abs_a[HALF-1:0], {HALF{1'b0}}} : abs_a;
              neg_q_reg   <= signed_op & (a_neg ^ b_neg);
              neg_r_reg   <= a_neg;
              w32_reg     <= Div32;
              rem_sel_reg <= rem_op;
              count_reg   <= Div32 ? CW'(HALF) : CW'(XLEN);
              state_reg   <= CALC;
            end
          end
        end
        CALC: begin
          rem_reg   <= step_rem;
          quo_reg   <= step_quo;
          count_reg <= count_reg - CW'(1);
          if (count_reg == CW'(1)) begin
            div_out_reg <= final_res;
            state_reg   <= DONE;
          end
        end
        DONE: begin
          if (out_ready_i)
            state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign div_ready_o = (state_reg == IDLE);
  assign out_valid_o = (state_reg == DONE);
  assign busy_o      = (state_reg == CALC) || (state_reg == DONE);
  assign DivOut      = div_out_reg;

endmodule
